// File: rtl/pulse_stretch_arbiter.sv
// Round-robin arbiter that turns short request pulses into one shared stretched pulse.
// Optional sticky lost-request flags: define PULSE_STRETCH_ARB_OVERFLOW_EN.
module pulse_stretch_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic [CNT_W-1:0] stretch_len,
    output logic             out_pulse,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy,
    output logic [N_REQ-1:0] pending,
    output logic [N_REQ-1:0] overflow,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STRETCH = 2'd1,
        S_GAP     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic [ID_W-1:0]  gid_q, gid_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [N_REQ-1:0] pending_q, pending_d;

    logic             grant_fire;
    logic             found;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  cand_id;
    logic [N_REQ-1:0] clr;

    // Only registered pending is arbitrated, so a new request costs one cycle of latency.
    assign grant_fire = ((state_q == S_IDLE) || (state_q == S_GAP)) && (|pending_q);

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand_id = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_id = ID_W'((int'(last_q) + i) % N_REQ);
            if (!found && pending_q[cand_id]) begin
                found   = 1'b1;
                gnt_idx = cand_id;
            end
        end
    end

    always_comb begin
        clr = '0;
        if (grant_fire) begin
            clr[gnt_idx] = 1'b1;
        end
    end

    // A fresh pulse on the same edge as its grant stays latched (set wins).
    assign pending_d = (pending_q & ~clr) | req_pulse;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        gid_d   = gid_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE, S_GAP: begin
                if (grant_fire) begin
                    state_d = S_STRETCH;
                    out_d   = 1'b1;
                    gid_d   = gnt_idx;
                    last_d  = gnt_idx;
                    cnt_d   = (stretch_len == '0) ? '0 : (stretch_len - CNT_W'(1));
                end else begin
                    state_d = S_IDLE;
                    out_d   = 1'b0;
                end
            end
            S_STRETCH: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    out_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                out_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
            gid_q     <= '0;
            last_q    <= ID_W'(N_REQ - 1);
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            gid_q     <= gid_d;
            last_q    <= last_d;
            pending_q <= pending_d;
        end
    end

`ifdef PULSE_STRETCH_ARB_OVERFLOW_EN
    logic [N_REQ-1:0] overflow_q;

    // A repeat pulse on an already-pending, not-now-granted requester is a lost request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= overflow_q | (req_pulse & pending_q & ~clr);
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = '0;
`endif

    assign out_pulse = out_q;
    assign grant_id  = gid_q;
    assign busy      = busy_q;
    assign pending   = pending_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pulse_stretch_arbiter.sv
// Directed bench for pulse_stretch_arbiter (N_REQ=4, CNT_W=4); expected values are hand-derived.
module tb_pulse_stretch_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_pulse;
    logic [3:0] stretch_len;
    logic       out_pulse;
    logic [1:0] grant_id;
    logic       busy;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

`ifdef PULSE_STRETCH_ARB_OVERFLOW_EN
    localparam logic [3:0] EXP_OVF = 4'b0010;
`else
    localparam logic [3:0] EXP_OVF = 4'b0000;
`endif

    pulse_stretch_arbiter #(.N_REQ(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_pulse  (req_pulse),
        .stretch_len(stretch_len),
        .out_pulse  (out_pulse),
        .grant_id   (grant_id),
        .busy       (busy),
        .pending    (pending),
        .overflow   (overflow),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then check the three cycle-level outputs.
    task automatic step_chk(input string tag, input logic e_out, input logic [1:0] e_gid,
                            input logic e_busy);
        @(posedge clk);
        #1;
        chk({tag, ".out"}, 32'(out_pulse), 32'(e_out));
        chk({tag, ".gid"}, 32'(grant_id), 32'(e_gid));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst         = 1'b1;
        req_pulse   = 4'b0000;
        stretch_len = 4'd0;
        #1;
        rst = 1'b0;
        #2;
        chk("rst.out", 32'(out_pulse), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.gid", 32'(grant_id), 0);
        chk("rst.pending", 32'(pending), 0);
        chk("rst.overflow", 32'(overflow), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Single pulse, length 3
        stretch_len = 4'd3;
        req_pulse   = 4'b0001;
        step_chk("single.k", 1'b0, 2'd0, 1'b0);
        chk("single.k.pending", 32'(pending), 32'h1);
        req_pulse = 4'b0000;
        step_chk("single.k1", 1'b1, 2'd0, 1'b1);
        chk("single.k1.pending", 32'(pending), 32'h0);
        step_chk("single.k2", 1'b1, 2'd0, 1'b1);
        step_chk("single.k3", 1'b1, 2'd0, 1'b1);
        step_chk("single.k4", 1'b0, 2'd0, 1'b1);
        step_chk("single.k5", 1'b0, 2'd0, 1'b0);
        chk("single.overflow", 32'(overflow), 0);

        // Simultaneous requests right after reset: 0 first, then 2
        do_reset();
        req_pulse = 4'b0101;
        step_chk("simul.k", 1'b0, 2'd0, 1'b0);
        chk("simul.k.pending", 32'(pending), 32'h5);
        req_pulse = 4'b0000;
        step_chk("simul.k1", 1'b1, 2'd0, 1'b1);
        chk("simul.k1.pending", 32'(pending), 32'h4);
        step_chk("simul.k2", 1'b1, 2'd0, 1'b1);
        step_chk("simul.k3", 1'b1, 2'd0, 1'b1);
        step_chk("simul.gap", 1'b0, 2'd0, 1'b1);
        step_chk("simul.k5", 1'b1, 2'd2, 1'b1);
        step_chk("simul.k6", 1'b1, 2'd2, 1'b1);
        step_chk("simul.k7", 1'b1, 2'd2, 1'b1);
        step_chk("simul.gap2", 1'b0, 2'd2, 1'b1);
        step_chk("simul.idle", 1'b0, 2'd2, 1'b0);

        // Round robin: grant 0, then 0011 gives 1 before 0
        stretch_len = 4'd1;
        req_pulse   = 4'b0001;
        step_chk("rr.a.k", 1'b0, 2'd2, 1'b0);
        req_pulse = 4'b0000;
        step_chk("rr.a.k1", 1'b1, 2'd0, 1'b1);
        step_chk("rr.a.gap", 1'b0, 2'd0, 1'b1);
        step_chk("rr.a.idle", 1'b0, 2'd0, 1'b0);
        req_pulse = 4'b0011;
        step_chk("rr.b.k", 1'b0, 2'd0, 1'b0);
        req_pulse = 4'b0000;
        step_chk("rr.b.k1", 1'b1, 2'd1, 1'b1);
        step_chk("rr.b.gap", 1'b0, 2'd1, 1'b1);
        step_chk("rr.b.k3", 1'b1, 2'd0, 1'b1);
        step_chk("rr.b.gap2", 1'b0, 2'd0, 1'b1);
        step_chk("rr.b.idle", 1'b0, 2'd0, 1'b0);

        // Zero length behaves as length 1
        stretch_len = 4'd0;
        req_pulse   = 4'b1000;
        step_chk("zero.k", 1'b0, 2'd0, 1'b0);
        req_pulse = 4'b0000;
        step_chk("zero.k1", 1'b1, 2'd3, 1'b1);
        step_chk("zero.gap", 1'b0, 2'd3, 1'b1);
        step_chk("zero.idle", 1'b0, 2'd3, 1'b0);

        // stretch_len change during STRETCH is ignored
        stretch_len = 4'd2;
        req_pulse   = 4'b0100;
        step_chk("len.k", 1'b0, 2'd3, 1'b0);
        req_pulse = 4'b0000;
        step_chk("len.k1", 1'b1, 2'd2, 1'b1);
        stretch_len = 4'd7;
        step_chk("len.k2", 1'b1, 2'd2, 1'b1);
        step_chk("len.gap", 1'b0, 2'd2, 1'b1);
        step_chk("len.idle", 1'b0, 2'd2, 1'b0);

        // Requester 1 pulses twice while 0 stretches: one grant, overflow per build
        stretch_len = 4'd3;
        req_pulse   = 4'b0001;
        step_chk("ovf.k", 1'b0, 2'd2, 1'b0);
        req_pulse = 4'b0000;
        step_chk("ovf.k1", 1'b1, 2'd0, 1'b1);
        req_pulse = 4'b0010;
        step_chk("ovf.k2", 1'b1, 2'd0, 1'b1);
        chk("ovf.k2.pending", 32'(pending), 32'h2);
        chk("ovf.k2.overflow", 32'(overflow), 0);
        req_pulse = 4'b0000;
        step_chk("ovf.k3", 1'b1, 2'd0, 1'b1);
        req_pulse = 4'b0010;
        step_chk("ovf.gap", 1'b0, 2'd0, 1'b1);
        chk("ovf.gap.pending", 32'(pending), 32'h2);
        chk("ovf.gap.overflow", 32'(overflow), 32'(EXP_OVF));
        req_pulse = 4'b0000;
        step_chk("ovf.k5", 1'b1, 2'd1, 1'b1);
        chk("ovf.k5.pending", 32'(pending), 32'h0);
        step_chk("ovf.k6", 1'b1, 2'd1, 1'b1);
        step_chk("ovf.k7", 1'b1, 2'd1, 1'b1);
        step_chk("ovf.gap2", 1'b0, 2'd1, 1'b1);
        step_chk("ovf.idle", 1'b0, 2'd1, 1'b0);
        chk("ovf.sticky", 32'(overflow), 32'(EXP_OVF));

        // Reset mid-STRETCH truncates the pulse and drops pending requests
        stretch_len = 4'd8;
        req_pulse   = 4'b0011;
        step_chk("mrst.k", 1'b0, 2'd1, 1'b0);
        req_pulse = 4'b0000;
        step_chk("mrst.k1", 1'b1, 2'd0, 1'b1);
        chk("mrst.k1.pending", 32'(pending), 32'h2);
        step_chk("mrst.k2", 1'b1, 2'd0, 1'b1);
        rst = 1'b0;
        #1;
        chk("mrst.async.out", 32'(out_pulse), 0);
        chk("mrst.async.pending", 32'(pending), 0);
        chk("mrst.async.busy", 32'(busy), 0);
        chk("mrst.async.gid", 32'(grant_id), 0);
        chk("mrst.async.overflow", 32'(overflow), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step_chk("mrst.after", 1'b0, 2'd0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
